coin_payout_ctrl: RTL and testbench
===================================

Name: coin_payout_ctrl

Overview:
- Payout controller at the actuator end of the change interface.
- The vending FSM hands it a change amount in pesos over a valid/ready handshake.
- It breaks the amount into Php10/Php5/Php1 coins, largest first, and pulses one hopper motor per coin.
- Each coin is confirmed by the coin-exit sensor. The block tracks per-hopper inventory and reports the amount paid and any shortfall.

Parameters:
- AMT_W, 8, width of amount/paid/short fields (pesos)
- INV_W, 8, width of each inventory counter
- INV1_INIT, 50, Php1 coin count at reset/refill
- INV5_INIT, 20, Php5 coin count at reset/refill
- INV10_INIT, 20, Php10 coin count at reset/refill
- PULSE_CYC, 4, motor pulse length in clock cycles (>=1)
- SENSE_TIMEOUT, 16, cycles allowed in WAIT_SENSE before a jam/empty is declared (>=2)

Ports:
- MAX10_CLK1_50  in  1  system clock; all registers update on its falling edge
- RESET  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  change request valid
- REQ_READY  out  1  high only in IDLE
- REQ_AMOUNT  in  AMT_W  change to pay, pesos
- REFILL  in  1  reload all inventories to INIT values; honoured in IDLE only
- SENSE  in  1  coin-exit sensor, one-cycle pulse per coin
- M1, M5, M10  out  1  hopper motor drives; at most one high at a time
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- PAID  out  AMT_W  pesos actually paid for the last request
- SHORT  out  AMT_W  pesos left unpaid for the last request
- FAULT  out  1  sticky jam flag
- INV1, INV5, INV10  out  INV_W  current coin counts

Behaviour:
- Reset (async, immediate):
  - state=IDLE; M1/M5/M10=0; DONE=0; PAID=0; SHORT=0; FAULT=0.
  - INVx=INVx_INIT; remaining=0.
- States: IDLE, PICK, DRIVE, WAIT_SENSE, REPORT.
- IDLE:
  - REQ_READY=1. On REQ_VALID, latch remaining=REQ_AMOUNT, clear paid accumulator, go to PICK.
  - REFILL=1 with no REQ_VALID: INVx<=INVx_INIT and FAULT<=0. Stay in IDLE.
  - REFILL and REQ_VALID together: the request wins; REFILL is ignored.
- PICK (one cycle):
  - Select the largest d in {10,5,1} with remaining>=d and INVd>0. Load pulse counter=PULSE_CYC and go to DRIVE.
  - If remaining==0, or no d qualifies, go to REPORT.
- DRIVE:
  - The selected motor is high for exactly PULSE_CYC consecutive cycles, then the block goes to WAIT_SENSE with its cycle counter at 0.
  - SENSE is ignored during DRIVE.
- WAIT_SENSE:
  - Motors low. SENSE=1 credits the coin: remaining-=d, paid+=d, INVd-=1, then go to PICK.
  - If the counter reaches SENSE_TIMEOUT-1 with no SENSE: INVd<=0 (hopper treated as empty), FAULT<=1, go to PICK. The next PICK falls back to smaller coins.
  - SENSE on the final timeout cycle counts as a credit, not a timeout.
- REPORT (one cycle): DONE=1, PAID<=paid, SHORT<=remaining, then go to IDLE.
  - PAID and SHORT hold until the next REPORT.
- SENSE outside WAIT_SENSE is ignored. REQ_VALID and REFILL while BUSY are ignored.
- Invariant: PAID+SHORT==REQ_AMOUNT of the accepted request.
- Arithmetic: unsigned. INVd is decremented only when INVd>0, so it never wraps. paid never exceeds the request.
- Per-coin latency: 1 (PICK) + PULSE_CYC + (sense delay + 1). A zero request gives DONE 2 cycles after acceptance with no motor activity.

Test Plan:
1. Default params, request 17, SENSE pulsed 2 cycles after each WAIT_SENSE entry -> motors fire M10, M5, M1, M1, each 4 cycles; DONE with PAID=17, SHORT=0; INV10=19, INV5=19, INV1=48; FAULT=0.
2. Request 10, SENSE withheld during the M10 wait -> timeout after 16 cycles; FAULT=1, INV10=0; then M5 fires twice with sensing; PAID=10, SHORT=0. A following REFILL in IDLE -> INV10=20, FAULT=0.
3. INV1_INIT=2, INV5_INIT=0, INV10_INIT=0, request 4 -> two M1 pulses; DONE with PAID=2, SHORT=2, INV1=0.
4. Request 0 -> DONE 2 cycles after handshake; PAID=0, SHORT=0; no motor ever high.
5. RESET asserted mid-DRIVE of an M5 pulse -> M5 low the same cycle (async); REQ_READY=1 after release; INV5=20, PAID=0.
6. REQ_VALID held high and REFILL pulsed during a payout -> no second acceptance until DONE; inventory unaffected by REFILL; the request is re-accepted on the cycle after returning to IDLE.

Source files
------------

// File: rtl/coin_payout_ctrl.sv
// Coin payout controller: splits a change amount into Php10/5/1 coins,
// pulses one hopper motor per coin and confirms each with the exit sensor.
module coin_payout_ctrl #(
   parameter int AMT_W         = 8,
   parameter int INV_W         = 8,
   parameter int INV1_INIT     = 50,
   parameter int INV5_INIT     = 20,
   parameter int INV10_INIT    = 20,
   parameter int PULSE_CYC     = 4,
   parameter int SENSE_TIMEOUT = 16
) (
   input  logic             MAX10_CLK1_50,
   input  logic             RESET,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [AMT_W-1:0] REQ_AMOUNT,
   input  logic             REFILL,
   input  logic             SENSE,
   output logic             M1,
   output logic             M5,
   output logic             M10,
   output logic             BUSY,
   output logic             DONE,
   output logic [AMT_W-1:0] PAID,
   output logic [AMT_W-1:0] SHORT,
   output logic             FAULT,
   output logic [INV_W-1:0] INV1,
   output logic [INV_W-1:0] INV5,
   output logic [INV_W-1:0] INV10
);

   localparam int CMAX  = (PULSE_CYC > SENSE_TIMEOUT) ? PULSE_CYC : SENSE_TIMEOUT;
   localparam int CNT_W = $clog2(CMAX + 1);

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(SENSE_TIMEOUT - 1);
   localparam logic [INV_W-1:0] I1_RST   = INV_W'(INV1_INIT);
   localparam logic [INV_W-1:0] I5_RST   = INV_W'(INV5_INIT);
   localparam logic [INV_W-1:0] I10_RST  = INV_W'(INV10_INIT);
   localparam logic [AMT_W-1:0] D1       = AMT_W'(1);
   localparam logic [AMT_W-1:0] D5       = AMT_W'(5);
   localparam logic [AMT_W-1:0] D10      = AMT_W'(10);

   typedef enum logic [2:0] {
      S_IDLE, S_PICK, S_DRIVE, S_WAIT, S_REPORT
   } state_t;

   typedef enum logic [1:0] {
      C_NONE, C_1, C_5, C_10
   } coin_t;

   state_t           state_q, state_d;
   coin_t            coin_q, coin_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] acc_q, acc_d;
   logic [AMT_W-1:0] paid_q, paid_d;
   logic [AMT_W-1:0] short_q, short_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [INV_W-1:0] inv1_q, inv1_d;
   logic [INV_W-1:0] inv5_q, inv5_d;
   logic [INV_W-1:0] inv10_q, inv10_d;
   logic             fault_q, fault_d;
   logic [AMT_W-1:0] coin_val;

   always_comb begin
      coin_val = '0;
      unique case (coin_q)
         C_1:     coin_val = D1;
         C_5:     coin_val = D5;
         C_10:    coin_val = D10;
         default: coin_val = '0;
      endcase
   end

   always_ff @(negedge MAX10_CLK1_50 or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         coin_q  <= C_NONE;
         rem_q   <= '0;
         acc_q   <= '0;
         paid_q  <= '0;
         short_q <= '0;
         cnt_q   <= '0;
         inv1_q  <= I1_RST;
         inv5_q  <= I5_RST;
         inv10_q <= I10_RST;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         coin_q  <= coin_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         paid_q  <= paid_d;
         short_q <= short_d;
         cnt_q   <= cnt_d;
         inv1_q  <= inv1_d;
         inv5_q  <= inv5_d;
         inv10_q <= inv10_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      coin_d  = coin_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      paid_d  = paid_q;
      short_d = short_q;
      cnt_d   = cnt_q;
      inv1_d  = inv1_q;
      inv5_d  = inv5_q;
      inv10_d = inv10_q;
      fault_d = fault_q;
      M1      = 1'b0;
      M5      = 1'b0;
      M10     = 1'b0;
      DONE    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (REQ_VALID) begin
               rem_d   = REQ_AMOUNT;
               acc_d   = '0;
               state_d = S_PICK;
            end else if (REFILL) begin
               inv1_d  = I1_RST;
               inv5_d  = I5_RST;
               inv10_d = I10_RST;
               fault_d = 1'b0;
            end
         end
         S_PICK: begin
            cnt_d   = PULSE_LD;
            state_d = S_DRIVE;
            // largest coin that fits and is still in stock
            if (rem_q >= D10 && inv10_q != '0) begin
               coin_d = C_10;
            end else if (rem_q >= D5 && inv5_q != '0) begin
               coin_d = C_5;
            end else if (rem_q >= D1 && inv1_q != '0) begin
               coin_d = C_1;
            end else begin
               state_d = S_REPORT;
            end
         end
         S_DRIVE: begin
            M1  = (coin_q == C_1);
            M5  = (coin_q == C_5);
            M10 = (coin_q == C_10);
            if (cnt_q == '0) begin
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (SENSE) begin
               rem_d   = rem_q - coin_val;
               acc_d   = acc_q + coin_val;
               state_d = S_PICK;
               unique case (coin_q)
                  C_1:  if (inv1_q != '0) inv1_d = inv1_q - INV_W'(1);
                  C_5:  if (inv5_q != '0) inv5_d = inv5_q - INV_W'(1);
                  C_10: if (inv10_q != '0) inv10_d = inv10_q - INV_W'(1);
                  default: ;
               endcase
            end else if (cnt_q == TO_LAST) begin
               // no coin seen: treat the hopper as empty and fall back
               fault_d = 1'b1;
               state_d = S_PICK;
               unique case (coin_q)
                  C_1:  inv1_d = '0;
                  C_5:  inv5_d = '0;
                  C_10: inv10_d = '0;
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REPORT: begin
            DONE    = 1'b1;
            paid_d  = acc_q;
            short_d = rem_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign REQ_READY = (state_q == S_IDLE);
   assign BUSY      = (state_q != S_IDLE);
   assign PAID      = paid_q;
   assign SHORT     = short_q;
   assign FAULT     = fault_q;
   assign INV1      = inv1_q;
   assign INV5      = inv5_q;
   assign INV10     = inv10_q;

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// Bench for coin_payout_ctrl: directed requests, queued expectations,
// a monitor that checks each completion and every motor pulse.
module tb_coin_payout_ctrl;

   localparam int PC = 4;

   typedef struct {
      int paid;
      int sh;
      int i1;
      int i5;
      int i10;
      int f;
      int seq;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] valid, ready, refill, m1, m5, m10, busy, done, fault;
   logic [1:0] sense = '0;
   logic [7:0] amt[2];
   logic [7:0] paid[2];
   logic [7:0] shrt[2];
   logic [7:0] inv1[2];
   logic [7:0] inv5[2];
   logic [7:0] inv10[2];

   int    total = 0;
   int    bad = 0;
   string tname = "reset";
   exp_t  qa[$];
   exp_t  qb[$];
   int    r1[2], r5[2], r10[2], sq[2], sd[2], wh[2];
   bit    pend[2];
   logic [1:0] prev_any = '0;

   initial forever #5 clk = ~clk;

   coin_payout_ctrl u_a (
      .MAX10_CLK1_50(clk), .RESET(rst),
      .REQ_VALID(valid[0]), .REQ_READY(ready[0]),
      .REQ_AMOUNT(amt[0]), .REFILL(refill[0]), .SENSE(sense[0]),
      .M1(m1[0]), .M5(m5[0]), .M10(m10[0]),
      .BUSY(busy[0]), .DONE(done[0]),
      .PAID(paid[0]), .SHORT(shrt[0]), .FAULT(fault[0]),
      .INV1(inv1[0]), .INV5(inv5[0]), .INV10(inv10[0])
   );

   coin_payout_ctrl #(
      .INV1_INIT(2), .INV5_INIT(0), .INV10_INIT(0)
   ) u_b (
      .MAX10_CLK1_50(clk), .RESET(rst),
      .REQ_VALID(valid[1]), .REQ_READY(ready[1]),
      .REQ_AMOUNT(amt[1]), .REFILL(refill[1]), .SENSE(sense[1]),
      .M1(m1[1]), .M5(m5[1]), .M10(m10[1]),
      .BUSY(busy[1]), .DONE(done[1]),
      .PAID(paid[1]), .SHORT(shrt[1]), .FAULT(fault[1]),
      .INV1(inv1[1]), .INV5(inv5[1]), .INV10(inv10[1])
   );

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int w, input int p, input int s,
                       input int a1, input int a5, input int a10,
                       input int f, input int q);
      exp_t e;
      e.paid = p; e.sh = s; e.i1 = a1; e.i5 = a5;
      e.i10 = a10; e.f = f; e.seq = q;
      if (w == 0) qa.push_back(e);
      else qb.push_back(e);
   endtask

   task automatic pulse_end(input int w, input logic m, input int code,
                            inout int r);
      if (m) begin
         r++;
      end else if (r > 0) begin
         cmp($sformatf("%s_pulse_len%0d", tname, code), r, PC);
         sq[w] = sq[w] * 4 + code;
         r = 0;
      end
   endtask

   task automatic mon(input int w);
      exp_t  e;
      string t;
      t = $sformatf("%s_%s", tname, (w == 0) ? "A" : "B");
      if (rst) begin
         r1[w] = 0; r5[w] = 0; r10[w] = 0; sq[w] = 0; pend[w] = 0;
         return;
      end
      if (pend[w]) begin
         pend[w] = 0;
         if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL %s_spurious_done: got 1 expected 0", t);
         end else begin
            if (w == 0) e = qa.pop_front();
            else e = qb.pop_front();
            cmp({t, "_paid"}, int'(paid[w]), e.paid);
            cmp({t, "_short"}, int'(shrt[w]), e.sh);
            cmp({t, "_inv1"}, int'(inv1[w]), e.i1);
            cmp({t, "_inv5"}, int'(inv5[w]), e.i5);
            cmp({t, "_inv10"}, int'(inv10[w]), e.i10);
            cmp({t, "_fault"}, int'(fault[w]), e.f);
            cmp({t, "_coinseq"}, sq[w], e.seq);
            sq[w] = 0;
         end
      end
      if (done[w]) pend[w] = 1;
      if (m1[w] | m5[w] | m10[w])
         cmp({t, "_onehot"}, int'(m1[w]) + int'(m5[w]) + int'(m10[w]), 1);
      pulse_end(w, m1[w], 1, r1[w]);
      pulse_end(w, m5[w], 2, r5[w]);
      pulse_end(w, m10[w], 3, r10[w]);
   endtask

   initial forever begin
      @(posedge clk);
      mon(0);
      mon(1);
   end

   // coin-exit sensor model: one pulse a couple of cycles after each motor pulse
   initial forever begin
      @(posedge clk);
      for (int w = 0; w < 2; w++) begin
         sense[w] = 1'b0;
         if (sd[w] > 0) begin
            sd[w]--;
            if (sd[w] == 0) sense[w] = 1'b1;
         end
         if (prev_any[w] && !(m1[w] | m5[w] | m10[w]) && !rst) begin
            if (wh[w] > 0) wh[w]--;
            else sd[w] = 2;
         end
         prev_any[w] = m1[w] | m5[w] | m10[w];
      end
   end

   task automatic issue(input int w, input int a);
      @(posedge clk);
      valid[w] = 1'b1;
      amt[w] = 8'(a);
      @(posedge clk);
      valid[w] = 1'b0;
   endtask

   task automatic wait_done(input int w, input int lim);
      int n = 0;
      while (!done[w] && n < lim) begin
         @(posedge clk);
         n++;
      end
      if (!done[w]) begin
         total++;
         bad++;
         $display("FAIL %s_done_timeout: got 0 expected 1", tname);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      valid = '0;
      refill = '0;
      amt[0] = '0;
      amt[1] = '0;
      wh[0] = 0;
      wh[1] = 0;
      sd[0] = 0;
      sd[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_ready", int'(ready[0]), 1);
      cmp("rst_busy", int'(busy[0]), 0);
      cmp("rst_done", int'(done[0]), 0);
      cmp("rst_motors", int'(m1[0] | m5[0] | m10[0]), 0);
      cmp("rst_paid", int'(paid[0]), 0);
      cmp("rst_short", int'(shrt[0]), 0);
      cmp("rst_fault", int'(fault[0]), 0);
      cmp("rst_inv1", int'(inv1[0]), 50);
      cmp("rst_inv5", int'(inv5[0]), 20);
      cmp("rst_inv10", int'(inv10[0]), 20);
      cmp("rst_b_inv1", int'(inv1[1]), 2);
      cmp("rst_b_inv5", int'(inv5[1]), 0);
      @(posedge clk);
      rst = 1'b0;

      tname = "t1";
      push(0, 17, 0, 48, 19, 19, 0, 229);
      issue(0, 17);
      wait_done(0, 200);

      tname = "t2";
      wh[0] = 1;
      push(0, 10, 0, 48, 17, 0, 1, 58);
      issue(0, 10);
      wait_done(0, 300);
      @(posedge clk);
      refill[0] = 1'b1;
      @(posedge clk);
      refill[0] = 1'b0;
      @(posedge clk);
      #1;
      cmp("t2_refill_inv10", int'(inv10[0]), 20);
      cmp("t2_refill_inv5", int'(inv5[0]), 20);
      cmp("t2_refill_inv1", int'(inv1[0]), 50);
      cmp("t2_refill_fault", int'(fault[0]), 0);

      tname = "t4";
      push(0, 0, 0, 50, 20, 20, 0, 0);
      @(posedge clk);
      valid[0] = 1'b1;
      amt[0] = 8'd0;
      @(posedge clk);
      valid[0] = 1'b0;
      #1;
      cmp("t4_busy_c1", int'(busy[0]), 1);
      cmp("t4_done_c1", int'(done[0]), 0);
      @(posedge clk);
      #1;
      cmp("t4_done_c2", int'(done[0]), 1);
      wait_done(0, 10);

      tname = "t6";
      push(0, 6, 0, 49, 19, 20, 0, 9);
      push(0, 6, 0, 48, 18, 20, 0, 9);
      @(posedge clk);
      valid[0] = 1'b1;
      amt[0] = 8'd6;
      repeat (3) @(posedge clk);
      refill[0] = 1'b1;
      @(posedge clk);
      refill[0] = 1'b0;
      cmp("t6_ready_busy", int'(ready[0]), 0);
      wait_done(0, 200);
      cmp("t6_ready_idle", int'(ready[0]), 1);
      @(negedge clk);
      #1;
      cmp("t6_reaccept", int'(busy[0]), 1);
      valid[0] = 1'b0;
      wait_done(0, 200);

      tname = "t5";
      issue(0, 5);
      n = 0;
      while (!m5[0] && n < 20) begin
         @(posedge clk);
         n++;
      end
      cmp("t5_m5_seen", int'(m5[0]), 1);
      #2;
      rst = 1'b1;
      #1;
      cmp("t5_m5_async", int'(m5[0]), 0);
      cmp("t5_busy_async", int'(busy[0]), 0);
      repeat (2) @(posedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cmp("t5_ready", int'(ready[0]), 1);
      cmp("t5_inv5", int'(inv5[0]), 20);
      cmp("t5_paid", int'(paid[0]), 0);
      cmp("t5_short", int'(shrt[0]), 0);

      tname = "t3";
      push(1, 2, 2, 0, 0, 0, 0, 5);
      issue(1, 4);
      wait_done(1, 200);

      cmp("qa_drained", qa.size(), 0);
      cmp("qb_drained", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
